sys_array_scheduler: RTL and testbench
======================================

# sys_array_scheduler

Round-robin job scheduler that shares one `sys_array_fetcher` instance between `NUM_REQ` requesters. It arbitrates pending matrix-multiply jobs and muxes the winner's weight and data matrices onto the fetcher. It sequences the fetcher's `load_params` and `start_comp` pulses, waits out the fixed computation latency, captures `out_data`, and returns it with a per-requester `done` pulse. It sits directly above the fetcher in the accelerator top level.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 8: element width.
- `ARRAY_W_W`, 2: weight matrix rows.
- `ARRAY_W_L`, 5: weight matrix columns.
- `ARRAY_A_W`, 5: data matrix rows.
- `ARRAY_A_L`, 2: data matrix columns.
- `COMP_LATENCY`, `ARRAY_A_L+ARRAY_A_W+ARRAY_W_W+4`: cycles from `fa_start_comp` to result-valid.
- `TIMEOUT`, 255: WAIT cycles before the error abort; must be greater than `COMP_LATENCY`.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: job request, level, one bit per requester.
- `req_keep_w` in `NUM_REQ`: requester's weights are unchanged since its last job.
- `req_data_b` in `NUM_REQ`×(`ARRAY_A_W`·`ARRAY_A_L`·`DATA_WIDTH`): per-requester data matrix, packed.
- `req_data_w` in `NUM_REQ`×(`ARRAY_W_W`·`ARRAY_W_L`·`DATA_WIDTH`): per-requester weight matrix, packed.
- `grant` out `NUM_REQ`: one-hot, held for the whole job.
- `done` out `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `result` out `ARRAY_W_W`·`ARRAY_A_L`·2·`DATA_WIDTH`: captured product. Valid with `done` and held until the next capture.
- `error` out 1: sticky timeout flag. Cleared only by reset.
- `busy` out 1: high in any state other than IDLE.
- `fa_load_params`, `fa_start_comp` out 1: fetcher controls.
- `fa_data_b`, `fa_data_w` out: muxed matrices for the granted requester. All zeros when no requester is granted.
- `fa_ready` in 1: fetcher ready (level, sticky).
- `fa_out_data` in: fetcher result.

## Operation
- States: IDLE, LOAD, START, WAIT, DONE.
- **IDLE.** If any `req` bit is set, pick the winner round-robin, starting at `rr_ptr`.
  - Register the one-hot `grant`.
  - Go to START if the winner equals `last_w_owner`, `req_keep_w[winner]`=1 and `w_valid`=1. Otherwise go to LOAD.
- **LOAD.** `fa_load_params`=1 for exactly 1 cycle. Set `last_w_owner`=winner and `w_valid`=1. Go to START.
- **START.** `fa_start_comp`=1 for exactly 1 cycle. Clear `wcnt`. Go to WAIT.
- **WAIT.** `wcnt` increments every cycle.
  - When `wcnt`=`COMP_LATENCY`-1 and `fa_ready`=1: `result`←`fa_out_data`, go to DONE.
  - If `wcnt` reaches `TIMEOUT`-1 first: set `error`=1 and `w_valid`=0, do not update `result`, go to DONE.
- **DONE.** `done[winner]`=1 for 1 cycle. `grant` drops. `rr_ptr`←(winner+1) mod `NUM_REQ`. Go to IDLE.
- Requesters hold `req`, `req_data_*` and `req_keep_w` stable from request until their `done`.
- Deasserting `req` mid-job does not abort the job; `done` is still pulsed.
- `fa_data_*` track the granted requester combinationally from the registered `grant`.
- `wcnt` is 16 bits.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `result`=0, `error`=0, `busy`=0.
  - `fa_load_params`=0, `fa_start_comp`=0.
  - `rr_ptr`=0, `w_valid`=0, `last_w_owner`=0, state=IDLE.
- Request sampled in IDLE at edge T:
  - `grant` visible from T+1.
  - LOAD at T+1, START at T+2.
  - `done` and `result` at T+3+`COMP_LATENCY`.
- With weight reuse (LOAD skipped), every step is one cycle earlier.
- Back-to-back: the next grant is issued the cycle after DONE, so there is 1 idle cycle between jobs.
- Simultaneous requests: lowest index at or after `rr_ptr` wins. A continuously requesting port waits at most `NUM_REQ`-1 jobs.
- A new `req` during LOAD/START/WAIT/DONE only waits; it never preempts the current job.
- Asynchronous reset mid-job: all outputs return to reset values immediately and no `done` is issued. The fetcher shares the same reset.

## Test plan
- **Single job.** Req0 with A=all 1, W=all 2 (default sizes) -> one `fa_load_params` pulse. `done[0]` at T+3+13. Every `result` element = 2·`ARRAY_A_L` = 4 (product of A and W with `ARRAY_A_L` terms).
- **Weight reuse.** Req0 runs twice; the second run has `req_keep_w[0]`=1 -> no second load pulse, `done` one cycle earlier. Then req1 with `req_keep_w[1]`=1 -> load pulse is issued (different owner).
- **Fairness.** Req0 and req1 held high for 4 jobs -> grants alternate 0,1,0,1 with 1 idle cycle between jobs. `result`s match each requester's matrices.
- **Timeout.** Fetcher ready tied 0 -> `error`=1 after `TIMEOUT` WAIT cycles, `done` pulsed, `result` unchanged. The next job reloads weights.
- **Reset mid-WAIT.** `reset_n` low at WAIT cycle 5 -> all outputs 0 asynchronously. After release, a new req0 completes normally.
- **Req drop.** Req0 drops during WAIT -> `done[0]` still pulses at the nominal cycle, then IDLE.

Source files
------------

// File: rtl/sys_array_scheduler.sv
// Round-robin job scheduler sharing one sys_array_fetcher between NUM_REQ requesters.
// Muxes the granted requester's matrices onto the fetcher, sequences load/start,
// waits for the result (with a timeout abort) and returns it with a done pulse.
module sys_array_scheduler #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ARRAY_W_W    = 2,
  parameter int unsigned ARRAY_W_L    = 5,
  parameter int unsigned ARRAY_A_W    = 5,
  parameter int unsigned ARRAY_A_L    = 2,
  parameter int unsigned COMP_LATENCY = ARRAY_A_L + ARRAY_A_W + ARRAY_W_W + 4,
  parameter int unsigned TIMEOUT      = 255,
  localparam int unsigned BW   = ARRAY_A_W * ARRAY_A_L * DATA_WIDTH,
  localparam int unsigned WW   = ARRAY_W_W * ARRAY_W_L * DATA_WIDTH,
  localparam int unsigned RW   = ARRAY_W_W * ARRAY_A_L * 2 * DATA_WIDTH,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_keep_w,
  input  logic [NUM_REQ*BW-1:0] req_data_b,
  input  logic [NUM_REQ*WW-1:0] req_data_w,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [RW-1:0]         result,
  output logic                  error,
  output logic                  busy,
  output logic                  fa_load_params,
  output logic                  fa_start_comp,
  output logic [BW-1:0]         fa_data_b,
  output logic [WW-1:0]         fa_data_w,
  input  logic                  fa_ready,
  input  logic [RW-1:0]         fa_out_data
);

  localparam logic [15:0] LatLast = 16'(COMP_LATENCY - 1);
  localparam logic [15:0] ToLast  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     win_q, win_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic                w_valid_q, w_valid_d;
  logic [15:0]         wcnt_q, wcnt_d;
  logic [RW-1:0]       result_q, result_d;
  logic                error_q, error_d;

  logic [IdxW-1:0]     pick;
  logic                found;
  logic [IdxW:0]       sum;
  logic [IdxW-1:0]     cand;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NUM_REQ)) sum = sum - (IdxW+1)'(NUM_REQ);
      cand = sum[IdxW-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state logic for the job sequencer and all its registered outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    win_d     = win_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    w_valid_d = w_valid_q;
    wcnt_d    = wcnt_q;
    result_d  = result_q;
    error_d   = error_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          win_d         = pick;
          // Fetcher still holds this requester's weights: skip the reload.
          if (pick == owner_q && req_keep_w[pick] && w_valid_q) state_d = StStart;
          else                                                  state_d = StLoad;
        end
      end
      StLoad: begin
        owner_d   = win_q;
        w_valid_d = 1'b1;
        state_d   = StStart;
      end
      StStart: begin
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wcnt_d = wcnt_q + 16'd1;
        if (fa_ready && wcnt_q >= LatLast) begin
          result_d = fa_out_data;
          grant_d  = '0;
          state_d  = StDone;
        end else if (wcnt_q >= ToLast) begin
          // Fetcher state is unknown after an abort, so force a reload next time.
          error_d   = 1'b1;
          w_valid_d = 1'b0;
          grant_d   = '0;
          state_d   = StDone;
        end
      end
      StDone: begin
        rr_ptr_d = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + IdxW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      win_q     <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      w_valid_q <= 1'b0;
      wcnt_q    <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      win_q     <= win_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      w_valid_q <= w_valid_d;
      wcnt_q    <= wcnt_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

  // Matrix mux driven by the registered one-hot grant; zero when nothing is granted.
  always_comb begin
    fa_data_b = '0;
    fa_data_w = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      fa_data_b = fa_data_b | ({BW{grant_q[i]}} & req_data_b[i*BW +: BW]);
      fa_data_w = fa_data_w | ({WW{grant_q[i]}} & req_data_w[i*WW +: WW]);
    end
  end

  // Completion pulse goes to the job's winner even though grant has already dropped.
  always_comb begin
    done = '0;
    if (state_q == StDone) done[win_q] = 1'b1;
  end

  assign grant          = grant_q;
  assign result         = result_q;
  assign error          = error_q;
  assign busy           = (state_q != StIdle);
  assign fa_load_params = (state_q == StLoad);
  assign fa_start_comp  = (state_q == StStart);

endmodule

// File: tb/tb_sys_array_scheduler.sv
// Directed bench for sys_array_scheduler with a small behavioural fetcher stand-in.
module tb_sys_array_scheduler;

  localparam int NR  = 2;
  localparam int DW  = 8;
  localparam int WRW = 2;
  localparam int WRL = 5;
  localparam int AW  = 5;
  localparam int AL  = 2;
  localparam int BW  = AW * AL * DW;
  localparam int WW  = WRW * WRL * DW;
  localparam int RW  = WRW * AL * 2 * DW;

  // Every product element is AL terms: 1*2+1*2 = 4 for req0, 3*1+3*1 = 6 for req1.
  localparam logic [RW-1:0] RES4 = {4{16'd4}};
  localparam logic [RW-1:0] RES6 = {4{16'd6}};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req, req_keep_w, grant, done;
  logic [NR*BW-1:0]  req_data_b;
  logic [NR*WW-1:0]  req_data_w;
  logic [RW-1:0]     result, fa_out;
  logic              error, busy, fa_load_params, fa_start_comp, ready_en;
  logic [BW-1:0]     fa_data_b;
  logic [WW-1:0]     fa_data_w;
  logic [WW-1:0]     fw;
  int                load_cnt = 0;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  sys_array_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_keep_w     (req_keep_w),
    .req_data_b     (req_data_b),
    .req_data_w     (req_data_w),
    .grant          (grant),
    .done           (done),
    .result         (result),
    .error          (error),
    .busy           (busy),
    .fa_load_params (fa_load_params),
    .fa_start_comp  (fa_start_comp),
    .fa_data_b      (fa_data_b),
    .fa_data_w      (fa_data_w),
    .fa_ready       (ready_en),
    .fa_out_data    (fa_out)
  );

  // Fetcher stand-in: AL-term dot product of latched weights and the current data.
  function automatic logic [RW-1:0] prod(input logic [WW-1:0] w, input logic [BW-1:0] a);
    logic [RW-1:0] r;
    logic [15:0]   acc;
    r = '0;
    for (int i = 0; i < WRW; i++) begin
      for (int j = 0; j < AL; j++) begin
        acc = '0;
        for (int k = 0; k < AL; k++)
          acc = acc + 16'(w[(i*WRL + k)*DW +: DW]) * 16'(a[(k*AL + j)*DW +: DW]);
        r[(i*AL + j)*2*DW +: 2*DW] = acc;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fw     <= '0;
      fa_out <= '0;
    end else begin
      if (fa_load_params) fw <= fa_data_w;
      if (fa_start_comp)  fa_out <= prod(fw, fa_data_b);
    end
  end

  always @(posedge clk) if (fa_load_params) load_cnt <= load_cnt + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One job for requester r; n counts cycles after the edge that samples req.
  task automatic do_job(input string tag, input int r, input logic keep, input int drop_at,
                        input int exp_n, input int exp_loads, input logic [RW-1:0] exp_res,
                        input logic exp_err);
    int n;
    int loads0;
    loads0        = load_cnt;
    req[r]        = 1'b1;
    req_keep_w[r] = keep;
    n = 0;
    while (n < 400 && done == '0) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check({tag, "_grant"}, 128'(grant), 128'(1) << r);
        check({tag, "_fa_b"}, 128'(fa_data_b), 128'(req_data_b[r*BW +: BW]));
      end
      if (n == drop_at) req[r] = 1'b0;
    end
    check({tag, "_lat"}, 128'(n), 128'(exp_n));
    check({tag, "_done"}, 128'(done), 128'(1) << r);
    check({tag, "_res"}, 128'(result), 128'(exp_res));
    check({tag, "_loads"}, 128'(load_cnt - loads0), 128'(exp_loads));
    check({tag, "_err"}, 128'(error), 128'(exp_err));
    req[r]        = 1'b0;
    req_keep_w[r] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int n;
    int g;
    reset_n    = 1'b0;
    req        = '0;
    req_keep_w = '0;
    ready_en   = 1'b1;
    for (int e = 0; e < BW / DW; e++) begin
      req_data_b[e*DW +: DW]      = 8'd1;
      req_data_b[BW + e*DW +: DW] = 8'd3;
    end
    for (int e = 0; e < WW / DW; e++) begin
      req_data_w[e*DW +: DW]      = 8'd2;
      req_data_w[WW + e*DW +: DW] = 8'd1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_result", 128'(result), 128'(0));
    check("rst_error", 128'(error), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ctl", 128'({fa_load_params, fa_start_comp}), 128'(0));
    check("rst_fa_w", 128'(fa_data_w), 128'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_job("single", 0, 1'b0, 0, 16, 1, RES4, 1'b0);
    do_job("reuse",  0, 1'b1, 0, 15, 0, RES4, 1'b0);
    do_job("own1",   1, 1'b1, 0, 16, 1, RES6, 1'b0);

    // Both requesters held high: winners alternate 0,1,0,1 with one idle cycle between.
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (n < 400 && done == '0) begin
        @(posedge clk); #1;
        n++;
      end
      check("fair_done", 128'(done), (j % 2 == 0) ? 128'(1) : 128'(2));
      check("fair_res", 128'(result), (j % 2 == 0) ? 128'(RES4) : 128'(RES6));
      if (j == 3) begin
        req = '0;
      end else begin
        g = 0;
        while (g < 10 && grant == '0) begin
          @(posedge clk); #1;
          g++;
        end
        // Done cycle, then one IDLE cycle, then the new grant.
        check("fair_gap", 128'(g), 128'(2));
        check("fair_grant", 128'(grant), (j % 2 == 0) ? 128'(2) : 128'(1));
      end
    end
    @(posedge clk); #1;
    check("fair_idle", 128'(busy), 128'(0));

    // Fetcher never ready: abort after TIMEOUT wait cycles, result kept from last job.
    ready_en = 1'b0;
    do_job("tmo", 0, 1'b1, 0, 3 + 255, 1, RES6, 1'b1);
    ready_en = 1'b1;
    do_job("reload", 0, 1'b1, 0, 16, 1, RES4, 1'b1);

    // Reset during wait cycle 5 of a job for requester 1.
    req[1] = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 128'(busy), 128'(1));
    check("mid_grant", 128'(grant), 128'(2));
    reset_n = 1'b0;
    #1;
    check("arst_grant", 128'(grant), 128'(0));
    check("arst_result", 128'(result), 128'(0));
    check("arst_error", 128'(error), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_fa_b", 128'(fa_data_b), 128'(0));
    req = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_job("post_rst", 0, 1'b0, 0, 16, 1, RES4, 1'b0);

    // Request dropped mid-wait: job still completes on time.
    do_job("drop", 0, 1'b1, 5, 15, 0, RES4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
